// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, header field layout and output-port FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the Req/Gnt/Full handshake encoding here is reused by every router port.
package noc_pkg;

   localparam int dataWidth = 32;

   // Header layout, LSB first: coordinates are dim bits each, IDs fill the upper half.
   localparam int dim          = 4;
   localparam int XDST_OFF     = 0;
   localparam int YDST_OFF     = 4;
   localparam int XSRC_OFF     = 8;
   localparam int YSRC_OFF     = 12;
   localparam int PACKETID_OFF = 16;
   localparam int MODULEID_OFF = 24;

   typedef struct packed {
      logic [7:0]     module_id;
      logic [7:0]     packet_id;
      logic [dim-1:0] y_src;
      logic [dim-1:0] x_src;
      logic [dim-1:0] y_dst;
      logic [dim-1:0] x_dst;
   } hdr_t;

   // Output-port handshake state: idle, or holding a request until granted.
   typedef enum logic {
      OUT_IDLE = 1'b0,
      OUT_WAIT = 1'b1
   } out_state_t;

   function automatic logic [7:0] hdr_packet_id(input logic [dataWidth-1:0] flit);
      hdr_t h;
      h = hdr_t'(flit);
      return h.packet_id;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with power-of-two depth; head data is presented combinationally.
// Latency: a push is visible at the head on the edge after it is written.
// Backpressure: caller must not push when full or pop when empty; flags are from the registered count.
module sync_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 4,
   parameter int ADDR  = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty
);

   localparam logic [ADDR:0] FULL_CNT = (ADDR+1)'(DEPTH);

   logic [DW-1:0]   mem [DEPTH];
   logic [ADDR-1:0] wr_ptr;
   logic [ADDR-1:0] rd_ptr;
   logic [ADDR:0]   count;

   // Pointers wrap naturally; count tracks occupancy so full and empty stay distinguishable.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ADDR'(1);
         if (pop)  rd_ptr <= rd_ptr + ADDR'(1);
         count <= count + {{ADDR{1'b0}}, push} - {{ADDR{1'b0}}, pop};
      end
   end

   // Storage needs no reset: entries are only read once count says they were written.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

endmodule

// File: rtl/local_input_buffer.sv
// Router local-port input stage: buffers injector packets and re-offers the head to the switch.
// Latency: push at edge E gives ReqDnStr from E+1 when empty; at most one packet per 2 cycles out.
// Backpressure: UpStrFull/withheld GntUpStr toward the PE; DnStrFull only gates new downstream requests.
module local_input_buffer
   import noc_pkg::*;
#(
   parameter int dataWidth = noc_pkg::dataWidth,
   parameter int DEPTH     = 4,
   parameter int ADDR      = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ReqUpStr,
   input  logic [dataWidth-1:0] PacketIn,
   output logic                 GntUpStr,
   output logic                 UpStrFull,
   output logic                 ReqDnStr,
   input  logic                 GntDnStr,
   input  logic                 DnStrFull,
   output logic [dataWidth-1:0] PacketOut
);

   logic                 push;
   logic                 pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [dataWidth-1:0] head;

   out_state_t           state;
   out_state_t           state_nxt;
   logic                 req_nxt;
   logic [dataWidth-1:0] pkt_nxt;

   // The GntUpStr term stops a second write while the injector still holds Req after its grant.
   // Full is the pre-edge value, so a same-edge pop never makes room for a push.
   assign push = ReqUpStr & ~GntUpStr & ~fifo_full;
   assign pop  = (state == OUT_WAIT) & GntDnStr;

   assign UpStrFull = fifo_full;

   sync_fifo #(
      .DW    (dataWidth),
      .DEPTH (DEPTH),
      .ADDR  (ADDR)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (PacketIn),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // One-cycle write grant for every accepted packet.
   always_ff @(posedge clk) begin
      if (!reset) GntUpStr <= 1'b0;
      else        GntUpStr <= push;
   end

   // Output FSM next state: latch the head and request, then hold until the switch grants.
   always_comb begin
      state_nxt = state;
      req_nxt   = ReqDnStr;
      pkt_nxt   = PacketOut;
      case (state)
         OUT_IDLE: begin
            if (!fifo_empty && !DnStrFull) begin
               state_nxt = OUT_WAIT;
               req_nxt   = 1'b1;
               pkt_nxt   = head;
            end
         end
         OUT_WAIT: begin
            if (GntDnStr) begin
               state_nxt = OUT_IDLE;
               req_nxt   = 1'b0;
            end
         end
         default: begin
            state_nxt = OUT_IDLE;
            req_nxt   = 1'b0;
         end
      endcase
   end

   // Output FSM registers; PacketOut stays stable for the whole request.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= OUT_IDLE;
         ReqDnStr  <= 1'b0;
         PacketOut <= '0;
      end else begin
         state     <= state_nxt;
         ReqDnStr  <= req_nxt;
         PacketOut <= pkt_nxt;
      end
   end

endmodule

// File: doc/local_input_buffer.md
# local_input_buffer

Router local-port input stage directly downstream of the per-PE packet injector. It accepts 32-bit single-flit packets from the injector over the Req/Gnt/Full handshake, stores them in a small circular FIFO, and re-offers the FIFO head to the router's routing/arbitration logic over the same Req/Gnt/Full protocol. The block decouples injector timing from switch allocation and provides back-pressure to the PE.

## Interface
- `dataWidth`, 32, flit/packet width; the header carries xDst, yDst, xSrc, ySrc, PacketID and ModuleID.
- `DEPTH`, 4, FIFO entries; must be a power of two, ≥2.
- `ADDR`, 2, log2(DEPTH); pointer width.
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `ReqUpStr`  in  1  injector request; held with stable data until granted.
- `PacketIn`  in  dataWidth  injector data, valid while ReqUpStr=1.
- `GntUpStr`  out  1  one-cycle grant; the packet was written.
- `UpStrFull`  out  1  FIFO full (count==DEPTH), combinational from count.
- `ReqDnStr`  out  1  request to router switch for the head packet.
- `GntDnStr`  in  1  grant from the router switch.
- `DnStrFull`  in  1  downstream cannot accept; blocks new requests.
- `PacketOut`  out  dataWidth  registered head packet, stable while ReqDnStr=1.

## Operation
- Storage: `mem[DEPTH]`, `wr_ptr` and `rd_ptr` (ADDR bits, natural wrap), and `count` (ADDR+1 bits, range 0..DEPTH).
- Write side:
  - Push when ReqUpStr=1, GntUpStr=0 and count<DEPTH.
  - On push: `mem[wr_ptr]<=PacketIn`, `wr_ptr++`, `GntUpStr<=1`.
  - Otherwise `GntUpStr<=0`.
  - The GntUpStr=0 qualifier blocks a double write during the cycle in which the injector is still holding Req after the grant.
- Read side FSM, 1 bit:
  - OUT_IDLE: if count!=0 and DnStrFull=0, then `PacketOut<=mem[rd_ptr]`, `ReqDnStr<=1`, go to OUT_WAIT. Otherwise stay.
  - OUT_WAIT: if GntDnStr=1, then `ReqDnStr<=0`, `rd_ptr++`, pop, go to OUT_IDLE. Otherwise hold ReqDnStr and PacketOut.
  - DnStrFull is ignored in OUT_WAIT.
- Count update:
  - `count <= count + push - pop`.
  - A simultaneous push and pop leaves count unchanged.
  - The full test uses the pre-edge count, so there is no push at count==DEPTH even if a pop occurs on the same edge.
- GntDnStr in OUT_IDLE is ignored.
- Reset (reset=0 at an edge) clears pointers, count, FSM to OUT_IDLE, ReqDnStr=0, GntUpStr=0 and PacketOut=0.
  - Any stored packets are discarded.
  - Reset takes effect mid-handshake too.

## Timing
- Reset values: GntUpStr=0, ReqDnStr=0, PacketOut=0; UpStrFull=0 (count=0).
- Upstream handshake:
  - ReqUpStr is first sampled high at edge E.
  - GntUpStr=1 during cycle E..E+1.
  - The injector drops Req at E+1; GntUpStr returns to 0 at E+1.
- Fall-through latency, empty FIFO: push at edge E, then ReqDnStr=1 from edge E+1.
- Downstream throughput: at most one packet per 2 cycles; ReqDnStr is low for ≥1 cycle between packets.
- UpStrFull rises in the cycle after the push that reaches DEPTH. It falls in the cycle after the first pop.

## Structure
- Shared package `noc_pkg`: dataWidth, header field offsets and dim, and FSM encodings `OUT_IDLE=1'b0`, `OUT_WAIT=1'b1`. The same handshake encoding is reused by router ports.
- One natural sub-module: `sync_fifo`, holding mem, pointers, count and the full/empty flags.
  - The top-level file keeps the write-grant logic and the output FSM.
- Target size: ~150–250 lines RTL.

## Test plan
- **Reset:** hold reset=0 for 3 cycles with ReqUpStr=1. Expect GntUpStr=0, ReqDnStr=0, PacketOut=0 and UpStrFull=0 throughout.
- **Single packet:** inject 0xA4C00015 with GntDnStr tied 1 cycle after ReqDnStr.
  - Expect exactly one GntUpStr pulse.
  - Expect ReqDnStr one cycle after the push, with PacketOut=0xA4C00015.
  - Expect count back to 0.
- **Fill:** DnStrFull=1 and 5 injector requests with IDs 1..5.
  - After 4 grants, UpStrFull=1; request 5 is not granted and ReqDnStr stays 0.
  - Release DnStrFull: outputs are IDs 1,2,3,4,5 in order, and ID 5 is granted after the first pop.
- **Simultaneous push/pop:** count=2 with push and pop on the same edge. Expect count=2, pointers each advanced by 1, and order preserved.
- **Wrap-around:** stream 10 packets through DEPTH=4 with random GntDnStr delay 0–3. Expect all 10 out in order with no duplicates and no loss.
- **Mid-handshake reset:** while ReqDnStr=1 waiting on grant with count=3, pulse reset=0 for 1 cycle.
  - Expect ReqDnStr=0 and count=0.
  - A GntDnStr arriving after the reset causes no pop.
